// File: rtl/regfile_write_arbiter_if.sv
// Register-file write port bundle: two writeback requesters, the clear request,
// and the registered write controls seen by the register file and forwarding logic.
interface regfile_write_arbiter_if #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 5
);
  logic                clear_req;
  logic                a_valid;
  logic [REG_BITS-1:0] a_index;
  logic [WIDTH-1:0]    a_data;
  logic                a_ready;
  logic                b_valid;
  logic [REG_BITS-1:0] b_index;
  logic [WIDTH-1:0]    b_data;
  logic                b_ready;
  logic                reg_write;
  logic [REG_BITS-1:0] write_index;
  logic [WIDTH-1:0]    write_data;
  logic                init_busy;
  logic                last_grant_b;

  modport slave (
    input  clear_req,
    input  a_valid, a_index, a_data,
    output a_ready,
    input  b_valid, b_index, b_data,
    output b_ready,
    output reg_write, write_index, write_data,
    output init_busy, last_grant_b
  );

  modport master (
    output clear_req,
    output a_valid, a_index, a_data,
    input  a_ready,
    output b_valid, b_index, b_data,
    input  b_ready,
    input  reg_write, write_index, write_data,
    input  init_busy, last_grant_b
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Single write port of the register file: round-robin between ALU (A) and load (B)
// writebacks, plus a zero-clear sweep of registers 1..N-1 after reset or on request.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_CLEAR | sweeping zero writes over indices 1..(1<<REG_BITS)-1, no grants
// ST_RUN   | arbitrating A/B writebacks, one registered write per cycle
module regfile_write_arbiter #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 5
) (
  input logic                    clk,
  input logic                    reset_n,
  regfile_write_arbiter_if.slave rf
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [REG_BITS-1:0] FIRST_IDX = REG_BITS'(1);
  localparam logic [REG_BITS-1:0] LAST_IDX  = '1;

  state_t              state_q, state_d;
  logic [REG_BITS-1:0] cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [REG_BITS-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                ptr_q, ptr_d;

  logic                grant_a;
  logic                grant_b;
  logic [REG_BITS-1:0] win_index;
  logic [WIDTH-1:0]    win_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= FIRST_IDX;
      rw_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      ptr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = 1'b0;
    idx_d     = idx_q;
    data_d    = data_q;
    ptr_d     = ptr_q;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    win_index = rf.a_index;
    win_data  = rf.a_data;

    case (state_q)
      ST_CLEAR: begin
        rw_d   = 1'b1;
        idx_d  = cnt_q;
        data_d = '0;
        cnt_d  = cnt_q + FIRST_IDX;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // ptr_q set means B won last time, so A has priority on a contest
        grant_a = rf.a_valid && !rf.clear_req && (!rf.b_valid || ptr_q);
        grant_b = rf.b_valid && !rf.clear_req && (!rf.a_valid || !ptr_q);
        if (grant_b) begin
          win_index = rf.b_index;
          win_data  = rf.b_data;
        end

        if (rf.clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = FIRST_IDX;
        end else if (grant_a || grant_b) begin
          ptr_d = grant_b;
          // register 0 is hardwired: the grant still counts, the write is dropped
          if (win_index != '0) begin
            rw_d   = 1'b1;
            idx_d  = win_index;
            data_d = win_data;
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
        cnt_d   = FIRST_IDX;
      end
    endcase
  end

  assign rf.a_ready      = grant_a;
  assign rf.b_ready      = grant_b;
  assign rf.reg_write    = rw_q;
  assign rf.write_index  = idx_q;
  assign rf.write_data   = data_q;
  assign rf.init_busy    = (state_q == ST_CLEAR);
  assign rf.last_grant_b = ptr_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized checks of regfile_write_arbiter against a transaction-level
// model: grant choice from the round-robin rule, expected write stream, and a golden file.
module tb_regfile_write_arbiter;
  localparam int WIDTH    = 16;
  localparam int REG_BITS = 5;
  localparam int NREG     = 1 << REG_BITS;
  localparam int MAXI     = NREG - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  regfile_write_arbiter_if #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) rf ();

  regfile_write_arbiter #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rf      (rf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;

  // reference model state
  bit          m_clearing;
  int          m_next;
  bit          m_rw;
  int          m_idx;
  logic [15:0] m_data;
  bit          m_ptr_b;
  logic [15:0] golden [NREG];
  logic [15:0] shadow [NREG];

  // values sampled at the last step
  logic        s_a_ready, s_b_ready, s_reg_write, s_busy, s_last_grant_b;
  logic [4:0]  s_write_index;
  logic [15:0] s_write_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rf.clear_req = 1'b0;
    rf.a_valid = 1'b0; rf.a_index = '0; rf.a_data = '0;
    rf.b_valid = 1'b0; rf.b_index = '0; rf.b_data = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 1'b0;
    #1;
    chk("rst_reg_write", 32'(rf.reg_write), 32'd0);
    chk("rst_write_index", 32'(rf.write_index), 32'd0);
    chk("rst_write_data", 32'(rf.write_data), 32'd0);
    chk("rst_init_busy", 32'(rf.init_busy), 32'd1);
    chk("rst_last_grant_b", 32'(rf.last_grant_b), 32'd1);
    chk("rst_a_ready", 32'(rf.a_ready), 32'd0);
    chk("rst_b_ready", 32'(rf.b_ready), 32'd0);
    m_clearing = 1'b1; m_next = 1; m_rw = 1'b0; m_idx = 0; m_data = '0; m_ptr_b = 1'b1;
    for (int r = 0; r < NREG; r++) golden[r] = 16'h0000;
    @(negedge clk);
    chk("rst_hold_reg_write", 32'(rf.reg_write), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // one clock cycle: check at negedge, advance the model, return 1 after the next posedge
  task automatic step();
    bit ea, eb;
    int w_idx;
    logic [15:0] w_data;
    @(negedge clk);
    s_a_ready = rf.a_ready; s_b_ready = rf.b_ready; s_reg_write = rf.reg_write;
    s_busy = rf.init_busy; s_last_grant_b = rf.last_grant_b;
    s_write_index = rf.write_index; s_write_data = rf.write_data;

    ea = 1'b0; eb = 1'b0;
    if (!m_clearing && !rf.clear_req) begin
      if (rf.a_valid && rf.b_valid) begin
        if (m_ptr_b) ea = 1'b1; else eb = 1'b1;
      end else begin
        ea = rf.a_valid;
        eb = rf.b_valid;
      end
    end

    chk("a_ready", 32'(s_a_ready), 32'(ea));
    chk("b_ready", 32'(s_b_ready), 32'(eb));
    chk("reg_write", 32'(s_reg_write), 32'(m_rw));
    if (m_rw) begin
      chk("write_index", 32'(s_write_index), 32'(m_idx));
      chk("write_data", 32'(s_write_data), 32'(m_data));
    end
    chk("init_busy", 32'(s_busy), 32'(m_clearing));
    chk("last_grant_b", 32'(s_last_grant_b), 32'(m_ptr_b));

    if (s_reg_write === 1'b1) begin
      wr_count++;
      shadow[s_write_index] = s_write_data;
    end

    if (m_clearing) begin
      m_rw = 1'b1; m_idx = m_next; m_data = '0;
      m_clearing = (m_next != MAXI);
      m_next++;
    end else if (rf.clear_req) begin
      m_rw = 1'b0; m_clearing = 1'b1; m_next = 1;
      for (int r = 0; r < NREG; r++) golden[r] = 16'h0000;
    end else if (ea || eb) begin
      w_idx  = ea ? int'(rf.a_index) : int'(rf.b_index);
      w_data = ea ? rf.a_data : rf.b_data;
      m_ptr_b = eb;
      if (w_idx != 0) begin
        m_rw = 1'b1; m_idx = w_idx; m_data = w_data;
        golden[w_idx] = w_data;
      end else begin
        m_rw = 1'b0;
      end
    end else begin
      m_rw = 1'b0;
    end

    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rnd_idx();
    if ($urandom_range(0, 2) == 0) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, MAXI));
  endfunction

  initial begin
    for (int r = 0; r < NREG; r++) shadow[r] = 16'hDEAD;
    idle_inputs();
    #2;
    apply_reset();

    // initial clear sweep
    repeat (33) step();
    chk("clear_write_count", 32'(wr_count), 32'd31);
    chk("clear_done_busy", 32'(s_busy), 32'd0);

    // contested A/B alternation, A first after reset
    rf.a_valid = 1'b1; rf.a_index = 5'd5; rf.a_data = 16'hAAAA;
    rf.b_valid = 1'b1; rf.b_index = 5'd6; rf.b_data = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("alt_a_ready", 32'(s_a_ready), 32'(i % 2 == 0));
      chk("alt_last_grant_b", 32'(s_last_grant_b), 32'(i % 2 == 0));
    end
    idle_inputs();
    step();
    chk("alt_final_index", 32'(s_write_index), 32'd6);

    // A alone
    rf.a_valid = 1'b1; rf.a_index = 5'd3; rf.a_data = 16'h1234;
    step();
    chk("solo_a_ready", 32'(s_a_ready), 32'd1);
    rf.a_valid = 1'b0;
    step();
    chk("solo_reg_write", 32'(s_reg_write), 32'd1);
    chk("solo_index", 32'(s_write_index), 32'd3);
    chk("solo_data", 32'(s_write_data), 32'h1234);
    step();
    chk("solo_idle_reg_write", 32'(s_reg_write), 32'd0);
    chk("solo_idle_hold_index", 32'(s_write_index), 32'd3);
    chk("solo_idle_hold_data", 32'(s_write_data), 32'h1234);

    // B alone so that A wins the next contest
    rf.b_valid = 1'b1; rf.b_index = 5'd7; rf.b_data = 16'h7777;
    step();
    rf.b_valid = 1'b0;
    step();
    step();

    // A writes index 0 while B waits
    rf.a_valid = 1'b1; rf.a_index = 5'd0; rf.a_data = 16'hFFFF;
    rf.b_valid = 1'b1; rf.b_index = 5'd9; rf.b_data = 16'h0BEE;
    step();
    chk("zero_a_ready", 32'(s_a_ready), 32'd1);
    chk("zero_b_ready", 32'(s_b_ready), 32'd0);
    rf.a_valid = 1'b0;
    step();
    chk("zero_no_write", 32'(s_reg_write), 32'd0);
    chk("zero_b_wins_next", 32'(s_b_ready), 32'd1);
    rf.b_valid = 1'b0;
    step();
    chk("zero_b_write_index", 32'(s_write_index), 32'd9);

    // clear_req while B pending
    rf.b_valid = 1'b1; rf.b_index = 5'd10; rf.b_data = 16'hCAFE;
    rf.clear_req = 1'b1;
    step();
    chk("clr_b_ready_drop", 32'(s_b_ready), 32'd0);
    rf.clear_req = 1'b0;
    repeat (31) step();
    chk("clr_b_wait", 32'(s_b_ready), 32'd0);
    step();
    chk("clr_b_first_run", 32'(s_b_ready), 32'd1);
    rf.b_valid = 1'b0;
    step();
    chk("clr_b_write_data", 32'(s_write_data), 32'hCAFE);

    // reset in the middle of a clear sweep
    rf.clear_req = 1'b1;
    step();
    rf.clear_req = 1'b0;
    repeat (12) step();
    chk("mid_clear_index", 32'(s_write_index), 32'd11);
    apply_reset();
    step();
    step();
    chk("restart_reg_write", 32'(s_reg_write), 32'd1);
    chk("restart_index", 32'(s_write_index), 32'd1);
    repeat (31) step();

    // randomized traffic; requesters hold until accepted
    for (int n = 0; n < 3000; n++) begin
      if (!rf.a_valid || s_a_ready) begin
        rf.a_valid = ($urandom_range(0, 3) != 0);
        rf.a_index = rnd_idx();
        rf.a_data  = 16'($urandom);
      end
      if (!rf.b_valid || s_b_ready) begin
        rf.b_valid = ($urandom_range(0, 3) != 0);
        rf.b_index = rnd_idx();
        rf.b_data  = 16'($urandom);
      end
      rf.clear_req = ($urandom_range(0, 149) == 0);
      step();
    end

    idle_inputs();
    repeat (40) step();
    for (int r = 1; r < NREG; r++) begin
      chk($sformatf("file_r%0d", r), 32'(shadow[r]), 32'(golden[r]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
